// File: rtl/vfu_issue_seq.sv
// Command-side sequencer for the vector function unit: latches one command,
// waits (bounded) for the VFU result, and hands it downstream on valid/ready.
module vfu_issue_seq #(
  parameter int N       = 64,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_inst,
  input  logic [N*16-1:0]   cmd_a,
  input  logic [N*16-1:0]   cmd_b,
  output logic [N*16-1:0]   vfu_a,
  output logic [N*16-1:0]   vfu_b,
  output logic [1:0]        vfu_inst,
  input  logic [N*16-1:0]   vfu_result,
  input  logic              vfu_tvalid,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [N*16-1:0]   res_data,
  output logic [1:0]        res_inst,
  output logic              res_timeout,
  output logic              busy
);

  localparam int W     = N * 16;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10,
    DONE  = 2'b11
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [CNT_W-1:0] cnt_r;
  logic             cmd_ready_r;
  logic             busy_r;
  logic             res_valid_r;
  logic             res_timeout_r;
  logic [1:0]       res_inst_r;
  logic [W-1:0]     res_data_r;
  logic [W-1:0]     vfu_a_r;
  logic [W-1:0]     vfu_b_r;
  logic [1:0]       vfu_inst_r;
  logic             accept_s;
  logic             capture_s;
  logic             expire_s;

  // cmd_ready_r is only ever set while the state register holds IDLE
  assign accept_s  = cmd_ready_r & cmd_valid;
  assign capture_s = (state_r == WAIT) & vfu_tvalid;
  assign expire_s  = (state_r == WAIT) & ~vfu_tvalid & (cnt_r == CNT_W'(TIMEOUT - 1));

  // Next-state decode
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_s = ISSUE;
        else          state_s = IDLE;
      end
      ISSUE: state_s = WAIT;
      WAIT: begin
        if (capture_s || expire_s) state_s = DONE;
        else                       state_s = WAIT;
      end
      DONE: begin
        if (res_ready) state_s = IDLE;
        else           state_s = DONE;
      end
      default: state_s = IDLE;
    endcase
  end

  // State register and status flags, registered from the next state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      cmd_ready_r <= 1'b0;
      busy_r      <= 1'b0;
      res_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      cmd_ready_r <= (state_s == IDLE);
      busy_r      <= (state_s != IDLE);
      res_valid_r <= (state_s == DONE);
    end
  end

  // Operand latch and WAIT-cycle counter (saturating, cleared on accept)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vfu_a_r    <= {W{1'b0}};
      vfu_b_r    <= {W{1'b0}};
      vfu_inst_r <= 2'b00;
      cnt_r      <= {CNT_W{1'b0}};
    end else if (accept_s) begin
      vfu_a_r    <= cmd_a;
      vfu_b_r    <= cmd_b;
      vfu_inst_r <= cmd_inst;
      cnt_r      <= {CNT_W{1'b0}};
    end else if ((state_r == WAIT) && (cnt_r != CNT_W'(TIMEOUT))) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Result capture; a result on the last timeout cycle takes priority
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_data_r    <= {W{1'b0}};
      res_inst_r    <= 2'b00;
      res_timeout_r <= 1'b0;
    end else if (capture_s) begin
      res_data_r    <= vfu_result;
      res_inst_r    <= vfu_inst_r;
      res_timeout_r <= 1'b0;
    end else if (expire_s) begin
      res_data_r    <= {W{1'b0}};
      res_inst_r    <= vfu_inst_r;
      res_timeout_r <= 1'b1;
    end else begin
      res_data_r    <= res_data_r;
      res_inst_r    <= res_inst_r;
      res_timeout_r <= res_timeout_r;
    end
  end

  assign cmd_ready   = cmd_ready_r;
  assign busy        = busy_r;
  assign res_valid   = res_valid_r;
  assign res_data    = res_data_r;
  assign res_inst    = res_inst_r;
  assign res_timeout = res_timeout_r;
  assign vfu_a       = vfu_a_r;
  assign vfu_b       = vfu_b_r;
  assign vfu_inst    = vfu_inst_r;

endmodule

// File: tb/tb_vfu_issue_seq.sv
// Scoreboard bench for vfu_issue_seq: a driver issues commands and plays the
// VFU, pushing expected results; a monitor pops and compares on res_valid.
module tb_vfu_issue_seq;

  localparam int N   = 8;
  localparam int TMO = 8;
  localparam int W   = N * 16;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [1:0]   cmd_inst = 2'b00;
  logic [W-1:0] cmd_a = '0;
  logic [W-1:0] cmd_b = '0;
  logic [W-1:0] vfu_a;
  logic [W-1:0] vfu_b;
  logic [1:0]   vfu_inst;
  logic [W-1:0] vfu_result = '0;
  logic         vfu_tvalid = 1'b0;
  logic         res_valid;
  logic         res_ready = 1'b0;
  logic [W-1:0] res_data;
  logic [1:0]   res_inst;
  logic         res_timeout;
  logic         busy;

  vfu_issue_seq #(.N(N), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_inst(cmd_inst),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .vfu_a(vfu_a), .vfu_b(vfu_b), .vfu_inst(vfu_inst),
    .vfu_result(vfu_result), .vfu_tvalid(vfu_tvalid),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_inst(res_inst), .res_timeout(res_timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  typedef struct {
    logic [W-1:0] data;
    logic [W-1:0] a;
    logic [1:0]   inst;
    logic         to;
    int           lat;
    int           hold;
    int           acc;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   xfer_cycle = -1;
  int   prev_acc = -1;
  bit   gap_check = 0;
  bit   b2b_check = 0;

  // Behavioural VFU: any lane-wise function will do, the sequencer is transparent
  function automatic logic [W-1:0] vfu_fn(logic [1:0] op, logic [W-1:0] a, logic [W-1:0] b);
    logic [W-1:0] r;
    logic [15:0]  x, y;
    r = '0;
    for (int i = 0; i < N; i++) begin
      x = a[16*i +: 16];
      y = b[16*i +: 16];
      case (op)
        2'b00:   r[16*i +: 16] = 16'(x * y);
        2'b01:   r[16*i +: 16] = x + y;
        2'b10:   r[16*i +: 16] = (x - y) ^ 16'h00ff;
        default: r[16*i +: 16] = x;
      endcase
    end
    return r;
  endfunction

  function automatic logic [W-1:0] rnd_vec();
    logic [W-1:0] v;
    for (int i = 0; i < W / 32; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  task automatic chk_v(string nm, logic [W-1:0] act, logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_i(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_idle(int rdy);
    chk_i("idle_cmd_ready", int'(cmd_ready), rdy);
    chk_i("idle_res_valid", int'(res_valid), 0);
    chk_i("idle_res_timeout", int'(res_timeout), 0);
    chk_i("idle_busy", int'(busy), 0);
    chk_i("idle_res_inst", int'(res_inst), 0);
    chk_i("idle_vfu_inst", int'(vfu_inst), 0);
    chk_v("idle_vfu_a", vfu_a, '0);
    chk_v("idle_vfu_b", vfu_b, '0);
    chk_v("idle_res_data", res_data, '0);
  endtask

  // Issue one command and behave as the VFU: result pulse d cycles into WAIT
  task automatic issue(logic [1:0] inst, logic [W-1:0] a, logic [W-1:0] b, int d,
                       int hold, bit level, bit junk_issue, int tail);
    int   waited;
    exp_t e;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_inst = inst; cmd_a = a; cmd_b = b;
    waited = 0;
    while (!cmd_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!cmd_ready) begin
      n_chk++; n_err++;
      $display("FAIL accept_wait: got cmd_ready=0 expected 1 within 100 cycles");
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_a = rnd_vec(); cmd_b = rnd_vec(); cmd_inst = 2'($urandom_range(0, 3));
    chk_v("vfu_a_latched", vfu_a, a);
    chk_v("vfu_b_latched", vfu_b, b);
    chk_i("vfu_inst_latched", int'(vfu_inst), int'(inst));
    chk_i("issue_cmd_ready", int'(cmd_ready), 0);
    chk_i("issue_busy", int'(busy), 1);
    if (gap_check && waited > 0) chk_i("accept_after_xfer", cycle, xfer_cycle + 1);
    if (b2b_check && prev_acc >= 0) chk_i("b2b_gap", cycle - prev_acc, 4);
    prev_acc = cycle;
    e.data = (d <= TMO) ? vfu_fn(inst, a, b) : '0;
    e.a    = a;
    e.inst = inst;
    e.to   = (d > TMO);
    e.lat  = 1 + ((d < TMO) ? d : TMO);
    e.hold = hold;
    e.acc  = cycle;
    exp_q.push_back(e);
    if (level) begin
      vfu_tvalid = 1'b1;
      vfu_result = vfu_fn(vfu_inst, vfu_a, vfu_b);
      repeat (2) @(posedge clk);
      #1;
    end else begin
      vfu_tvalid = junk_issue;
      vfu_result = rnd_vec();
      for (int k = 1; k <= d; k++) begin
        @(posedge clk); #1;
        if (k == d) begin
          vfu_tvalid = 1'b1;
          vfu_result = vfu_fn(vfu_inst, vfu_a, vfu_b);
        end else begin
          vfu_tvalid = 1'b0;
          vfu_result = rnd_vec();
        end
      end
      for (int k = 0; k < tail; k++) begin
        @(posedge clk); #1;
        vfu_tvalid = 1'b1;
        vfu_result = rnd_vec();
      end
      @(posedge clk); #1;
      vfu_tvalid = 1'b0;
      vfu_result = rnd_vec();
    end
  endtask

  // Monitor: pops on each new result, then checks it is held until transfer
  initial begin
    exp_t cur;
    int   vcnt;
    bit   in_res;
    bit   stray;
    in_res = 0; stray = 0; vcnt = 0;
    cur.hold = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        in_res = 0; stray = 0; res_ready = 1'b0;
      end else if (res_valid) begin
        if (!in_res) begin
          in_res = 1; vcnt = 0;
          if (exp_q.size() == 0) begin
            stray = 1; cur.hold = 0;
            n_chk++; n_err++;
            $display("FAIL unexpected_result: got res_valid=1 expected no result");
          end else begin
            cur = exp_q.pop_front();
            chk_v("res_data", res_data, cur.data);
            chk_i("res_inst", int'(res_inst), int'(cur.inst));
            chk_i("res_timeout", int'(res_timeout), int'(cur.to));
            chk_i("res_latency", cycle - cur.acc, cur.lat);
          end
        end else if (!stray) begin
          chk_v("res_data_held", res_data, cur.data);
          chk_i("res_inst_held", int'(res_inst), int'(cur.inst));
          chk_i("res_timeout_held", int'(res_timeout), int'(cur.to));
        end
        if (!stray) chk_v("vfu_a_stable", vfu_a, cur.a);
        chk_i("done_cmd_ready", int'(cmd_ready), 0);
        chk_i("done_busy", int'(busy), 1);
        res_ready = (vcnt >= cur.hold);
        if (res_ready) xfer_cycle = cycle + 1;
        vcnt++;
      end else begin
        in_res = 0; stray = 0; res_ready = 1'b0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] pat;
    logic [1:0]   op;
    int           wt;

    repeat (3) @(negedge clk);
    check_idle(0);
    rst = 1'b1;
    @(posedge clk); #1;
    check_idle(1);

    // Bypass with tvalid held high
    for (int i = 0; i < N; i++) pat[16*i +: 16] = 16'h0000 + 16'(i);
    issue(2'b11, pat, rnd_vec(), 1, 0, 1, 0, 0);
    vfu_tvalid = 1'b0;

    // Mult, 6-cycle VFU, long backpressure with later tvalid noise, then a waiting command
    issue(2'b00, rnd_vec(), rnd_vec(), 6, 10, 0, 1, 4);
    gap_check = 1;
    issue(2'b01, rnd_vec(), rnd_vec(), 2, 0, 0, 0, 0);
    gap_check = 0;

    // Timeout, then a capture on the final timeout cycle
    issue(2'b10, rnd_vec(), rnd_vec(), TMO + 1, 1, 0, 0, 0);
    issue(2'b01, rnd_vec(), rnd_vec(), TMO, 0, 0, 0, 0);

    // Back-to-back, one command per four cycles
    b2b_check = 1; prev_acc = -1;
    for (int i = 0; i < 4; i++) issue(2'(i), rnd_vec(), rnd_vec(), 1, 0, 0, 0, 0);
    b2b_check = 0;

    // Reset during WAIT with a result in flight
    wt = 0;
    while ((exp_q.size() != 0 || res_valid) && wt < 200) begin @(negedge clk); wt++; end
    @(negedge clk);
    cmd_valid = 1'b1; cmd_inst = 2'b00; cmd_a = rnd_vec(); cmd_b = rnd_vec();
    wt = 0;
    while (!cmd_ready && wt < 100) begin @(negedge clk); wt++; end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vfu_tvalid = 1'b1; vfu_result = rnd_vec();
    rst = 1'b0;
    #1;
    check_idle(0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check_idle(1);
    vfu_tvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk_i("post_reset_no_result", int'(res_valid), 0);
    end

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      issue(op, rnd_vec(), rnd_vec(), $urandom_range(1, TMO + 2), $urandom_range(0, 3),
            0, 1'($urandom_range(0, 1)), $urandom_range(0, 2));
    end

    wt = 0;
    while ((exp_q.size() != 0 || res_valid) && wt < 200) begin @(negedge clk); wt++; end
    chk_i("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
